display_scheduler: RTL and testbench

Time-shares the 4-digit seven-segment display between up to four on-board value sources, such as PC, ALU result, register readback and switch value. Sits between the single-cycle core's debug taps and the display driver and produces the driver's 13-bit `num` input. Supports two modes:
- round-robin auto-rotation with a programmable dwell time;
- a manual override that pins one source.

---
 rtl/display_pkg.sv | 21 ++
 rtl/disp_rr_pick.sv | 28 ++
 rtl/display_scheduler.sv | 154 +++++++++++++++
 tb/tb_display_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Source indices are 2 bits wide, so at most four sources are supported.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_MANUAL = 2'd2
    } state_t;

    localparam logic [12:0] NUM_MAX    = 13'd8191;
    localparam int          N_SRC_DEF  = 4;
    localparam int          DATA_W_DEF = 32;
    localparam int          IDX_W      = 2;

    // Index that follows idx in round-robin order over n sources.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
        return IDX_W'((int'(idx) + 1) % n);
    endfunction

endpackage

// File: rtl/disp_rr_pick.sv
// Combinational round-robin picker: the first requester at or after i_start
// wins, wrapping modulo N_SRC.
module disp_rr_pick
    import display_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    logic [N_SRC-1:0] w_rot;

    // Bit k of w_rot is the request of source (i_start + k) mod N_SRC.
    assign w_rot   = N_SRC'({i_req, i_req} >> i_start);
    assign o_found = |i_req;

    // NOTE: every signal written in always_comb is given a default first so no latch is inferred.
    always_comb begin
        o_idx = i_start;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (w_rot[k]) o_idx = IDX_W'((int'(i_start) + k) % N_SRC);
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the 4-digit display between N_SRC value sources with
// round-robin dwell rotation and a manual override; drives the 13-bit num.
module display_scheduler
    import display_pkg::*;
#(
    parameter int N_SRC  = N_SRC_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DWELL  = 100_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SRC-1:0]        req,
    input  logic [N_SRC*DATA_W-1:0] data,
    input  logic                    hold,
    input  logic                    manual_en,
    input  logic [IDX_W-1:0]        manual_sel,
    output logic [12:0]             num,
    output logic [IDX_W-1:0]        sel,
    output logic [N_SRC-1:0]        grant,
    output logic                    done,
    output logic                    ovf
);

    localparam int CNT_W = $clog2(DWELL);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_last_sel;
    logic [IDX_W-1:0]   r_sel;
    logic [N_SRC-1:0]   r_grant;
    logic [12:0]        r_num;
    logic               r_done;
    logic               r_ovf;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   w_last_nxt;
    logic [IDX_W-1:0]   w_sel_nxt;
    logic               w_show_nxt;
    logic               w_done_nxt;
    logic [IDX_W-1:0]   w_start;
    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic               w_cur_req;
    logic               w_expire;
    logic               w_manual_ok;
    logic [DATA_W-1:0]  w_value;
    logic               w_ovf_nxt;
    logic [12:0]        w_num_nxt;
    logic [N_SRC-1:0]   w_grant_nxt;

    // Leaving manual mode resumes rotation after the pinned source.
    assign w_start     = wrap_inc((r_state == ST_MANUAL) ? manual_sel : r_last_sel, N_SRC);
    assign w_cur_req   = |(req & r_grant);
    assign w_expire    = (r_state == ST_SHOW) && !hold && (r_cnt == CNT_W'(DWELL - 1));
    assign w_manual_ok = (int'(manual_sel) < N_SRC);

    disp_rr_pick #(.N_SRC(N_SRC)) u_pick (
        .i_req   (req),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last_sel;
        w_sel_nxt   = r_sel;
        w_show_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        if (manual_en) begin
            w_state_nxt = ST_MANUAL;
            w_cnt_nxt   = '0;
            w_sel_nxt   = manual_sel;
            w_show_nxt  = w_manual_ok;
        end else begin
            case (r_state)
                ST_SHOW: begin
                    if (w_expire || !w_cur_req) begin
                        // Expiry wins over a coincident release, so done still pulses.
                        w_done_nxt = w_expire;
                        w_cnt_nxt  = '0;
                        if (w_found) begin
                            w_sel_nxt  = w_pick;
                            w_last_nxt = w_pick;
                            w_show_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_show_nxt = 1'b1;
                        if (!hold) w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_IDLE, ST_MANUAL: begin
                    w_cnt_nxt = '0;
                    if (w_found) begin
                        w_state_nxt = ST_SHOW;
                        w_sel_nxt   = w_pick;
                        w_last_nxt  = w_pick;
                        w_show_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_value = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_show_nxt && (w_sel_nxt == IDX_W'(i))) w_value = data[i*DATA_W +: DATA_W];
        end
    end

    // Any set bit above bit 12 means the value exceeds NUM_MAX.
    assign w_ovf_nxt   = |w_value[DATA_W-1:13];
    assign w_num_nxt   = w_ovf_nxt ? NUM_MAX : w_value[12:0];
    assign w_grant_nxt = w_show_nxt ? (N_SRC'(1) << w_sel_nxt) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_last_sel <= IDX_W'(N_SRC - 1);
            r_sel      <= '0;
            r_grant    <= '0;
            r_num      <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last_sel <= w_last_nxt;
            r_sel      <= w_sel_nxt;
            r_grant    <= w_grant_nxt;
            r_num      <= w_num_nxt;
            r_done     <= w_done_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

    assign num   = r_num;
    assign sel   = r_sel;
    assign grant = r_grant;
    assign done  = r_done;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: directed scenarios plus random
// stimulus, all compared against a behavioural model of the scheduling rules.
module tb_display_scheduler;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DWELL = 4;

    localparam int M_IDLE = 0;
    localparam int M_SHOW = 1;
    localparam int M_MAN  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic            hold;
    logic            manual_en;
    logic [1:0]      manual_sel;
    logic [12:0]     num;
    logic [1:0]      sel;
    logic [N-1:0]    grant;
    logic            done;
    logic            ovf;

    int unsigned src_val [N];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: mode, displayed source, last winner and dwell cycles remaining.
    int         m_mode = M_IDLE;
    logic [1:0] m_cur  = 2'd0;
    logic [1:0] m_last = 2'd3;
    int         m_left = 0;

    logic [12:0]  e_num   = '0;
    logic [1:0]   e_sel   = '0;
    logic [N-1:0] e_grant = '0;
    logic         e_done  = 1'b0;
    logic         e_ovf   = 1'b0;

    int rot_exp [13] = '{10, 10, 10, 10, 20, 20, 20, 20, 40, 40, 40, 40, 10};

    display_scheduler #(.N_SRC(N), .DATA_W(DW), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data       (data),
        .hold       (hold),
        .manual_en  (manual_en),
        .manual_sel (manual_sel),
        .num        (num),
        .sel        (sel),
        .grant      (grant),
        .done       (done),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) data[i*DW +: DW] = src_val[i];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // First requester strictly after base in round-robin order, or -1.
    function automatic int rr_after(input logic [1:0] base, input logic [N-1:0] rq);
        for (int k = 1; k <= N; k++) begin
            logic [1:0] c;
            c = 2'(int'(base) + k);
            if (rq[c]) return int'(c);
        end
        return -1;
    endfunction

    task automatic model_edge();
        int d;
        int p;
        bit expired;
        d = -1;
        if (rst) begin
            m_mode = M_IDLE;
            m_last = 2'd3;
            m_left = 0;
            e_sel  = 2'd0;
            e_done = 1'b0;
        end else begin
            e_done = 1'b0;
            if (manual_en) begin
                m_mode = M_MAN;
                e_sel  = manual_sel;
                d      = int'(manual_sel);
            end else begin
                p = -2;
                if (m_mode == M_SHOW) begin
                    expired = !hold && (m_left == 1);
                    if (expired || !req[m_cur]) begin
                        e_done = expired;
                        p = rr_after(m_cur, req);
                    end else begin
                        if (!hold) m_left--;
                        d = int'(m_cur);
                    end
                end else if (m_mode == M_MAN) begin
                    p = rr_after(manual_sel, req);
                end else begin
                    p = rr_after(m_last, req);
                end
                if (p >= 0) begin
                    m_mode = M_SHOW;
                    m_cur  = 2'(p);
                    m_last = 2'(p);
                    m_left = DWELL;
                    e_sel  = 2'(p);
                    d      = p;
                end else if (p == -1) begin
                    m_mode = M_IDLE;
                end
            end
        end
        if (d >= 0 && d < N) begin
            e_grant = N'(1) << d;
            e_ovf   = src_val[d] > 32'd8191;
            e_num   = e_ovf ? 13'd8191 : 13'(src_val[d]);
        end else begin
            e_grant = '0;
            e_ovf   = 1'b0;
            e_num   = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("num", 32'(num), 32'(e_num));
        check("sel", 32'(sel), 32'(e_sel));
        check("grant", 32'(grant), 32'(e_grant));
        check("done", 32'(done), 32'(e_done));
        check("ovf", 32'(ovf), 32'(e_ovf));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        hold       = 1'b0;
        manual_en  = 1'b0;
        manual_sel = 2'd0;
        for (int i = 0; i < N; i++) src_val[i] = 0;

        // Reset and idle.
        tick();
        tick();
        check("rst_num", 32'(num), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b0;
        tick();
        check("idle_grant", 32'(grant), 0);

        // Rotation over sources 0, 1, 3.
        req = 4'b1011;
        src_val[0] = 10; src_val[1] = 20; src_val[2] = 30; src_val[3] = 40;
        for (int i = 0; i < 13; i++) begin
            tick();
            check("rot_num", 32'(num), 32'(rot_exp[i]));
            check("rot_done", 32'(done), 32'((i % 4 == 0) && (i != 0)));
            check("rot_g2", 32'(grant[2]), 0);
        end

        // Clamp boundaries.
        do_reset();
        req = 4'b0001;
        src_val[0] = 9000;
        tick();
        check("clamp_num", 32'(num), 8191);
        check("clamp_ovf", 32'(ovf), 1);
        src_val[0] = 8191;
        tick();
        check("max_num", 32'(num), 8191);
        check("max_ovf", 32'(ovf), 0);
        src_val[0] = 8192;
        tick();
        check("over_ovf", 32'(ovf), 1);

        // Early release at cnt=1, then coincident release at cnt=3.
        do_reset();
        req = 4'b0011;
        src_val[0] = 1; src_val[1] = 2; src_val[2] = 3; src_val[3] = 4;
        repeat (6) tick();
        check("rel_pre_sel", 32'(sel), 1);
        req = 4'b0001;
        tick();
        check("rel_sel", 32'(sel), 0);
        check("rel_done", 32'(done), 0);
        req = 4'b0011;
        repeat (3) tick();
        req = 4'b0010;
        tick();
        check("coin_done", 32'(done), 1);
        check("coin_sel", 32'(sel), 1);

        // Hold mid-dwell.
        do_reset();
        req = 4'b0011;
        tick();
        tick();
        hold = 1'b1;
        repeat (10) begin
            tick();
            check("hold_sel", 32'(sel), 0);
            check("hold_done", 32'(done), 0);
        end
        hold = 1'b0;
        tick();
        check("post_hold_d1", 32'(done), 0);
        tick();
        check("post_hold_d2", 32'(done), 0);
        tick();
        check("post_hold_d3", 32'(done), 1);
        check("post_hold_sel", 32'(sel), 1);

        // Manual override, release, then reset mid-SHOW.
        req = 4'b0001;
        manual_en  = 1'b1;
        manual_sel = 2'd2;
        tick();
        check("man_grant", 32'(grant), 32'h4);
        req = 4'b1111;
        tick();
        check("man_grant2", 32'(grant), 32'h4);
        manual_en = 1'b0;
        tick();
        check("man_rel_sel", 32'(sel), 3);
        check("man_rel_grant", 32'(grant), 32'h8);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_num", 32'(num), 0);
        check("mid_rst_sel", 32'(sel), 0);
        check("mid_rst_grant", 32'(grant), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_ovf", 32'(ovf), 0);
        rst = 1'b0;

        // Random traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       src_val[i] = $urandom_range(0, 8191);
                        1:       src_val[i] = $urandom_range(8190, 8193);
                        2:       src_val[i] = $urandom;
                        default: src_val[i] = $urandom_range(0, 100);
                    endcase
                end
            end
            hold = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) manual_en = ~manual_en;
            manual_sel = 2'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
